// File: rtl/matmul_operand_feeder.sv
// -----------------------------------------------------------------------------
// matmul_operand_feeder
//
// Holds operand matrices A (N x K) and B (K x M) in local register banks and
// streams them, diagonally skewed, to the left and top edges of a systolic
// matmul array. Row i of A is delayed i steps and column j of B is delayed
// j steps. A feed lasts T = K + max(N,M) - 1 steps. It is followed by a
// single DONE cycle that pulses done_o.
//
// Ports:
//   clk           sole clock, rising edge
//   rst_ni        synchronous active-low reset
//   load_valid_i  element write request
//   load_ready_o  high only while idle; a write is taken on valid && ready
//   load_sel_i    0 = matrix A, 1 = matrix B
//   load_idx_i    row-major linear element index
//   load_data_i   element value
//   start_i       feed request, sampled only while idle
//   busy_o        high during the feed and the DONE cycle
//   feed_valid_o  high while a_row_o / b_col_o carry a skew word
//   a_row_o       N lanes of DATA_WIDTH, lane i = left input of array row i
//   b_col_o       M lanes of DATA_WIDTH, lane j = top input of array column j
//   done_o        one-cycle pulse after the last feed word
//   err_o         one-cycle pulse for a dropped write or a refused start
//
// Optional build macro: MATMUL_FEEDER_LOADCHK_EN
//   When defined, a per-element "written" bitmap is kept for A and B. A start
//   is refused, and err_o pulses, unless every element of both banks has
//   been written since the last reset or completed feed.
// -----------------------------------------------------------------------------
module matmul_operand_feeder #(
    parameter int N          = 4,
    parameter int K          = 4,
    parameter int M          = 4,
    parameter int DATA_WIDTH = 8,
    localparam int A_SZ      = N * K,
    localparam int B_SZ      = K * M,
    localparam int MAX_SZ    = (A_SZ > B_SZ) ? A_SZ : B_SZ,
    localparam int IDX_W     = (MAX_SZ > 1) ? $clog2(MAX_SZ) : 1
) (
    input  logic                    clk,
    input  logic                    rst_ni,
    input  logic                    load_valid_i,
    output logic                    load_ready_o,
    input  logic                    load_sel_i,
    input  logic [IDX_W-1:0]        load_idx_i,
    input  logic [DATA_WIDTH-1:0]   load_data_i,
    input  logic                    start_i,
    output logic                    busy_o,
    output logic                    feed_valid_o,
    output logic [N*DATA_WIDTH-1:0] a_row_o,
    output logic [M*DATA_WIDTH-1:0] b_col_o,
    output logic                    done_o,
    output logic                    err_o
);

    localparam int T  = K + ((N > M) ? N : M) - 1;
    localparam int TW = $clog2(T + 1);
    localparam logic [TW-1:0] T_LAST = TW'(T - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FEED = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                  state_r;
    logic [TW-1:0]           t_r;
    logic                    load_ready_r;
    logic                    busy_r;
    logic                    feed_valid_r;
    logic                    done_r;
    logic                    err_r;
    logic [N*DATA_WIDTH-1:0] a_row_r;
    logic [M*DATA_WIDTH-1:0] b_col_r;

    logic [DATA_WIDTH-1:0]   bank_a_r     [A_SZ];
    logic [DATA_WIDTH-1:0]   bank_b_r     [B_SZ];
    logic [DATA_WIDTH-1:0]   bank_a_nxt_s [A_SZ];
    logic [DATA_WIDTH-1:0]   bank_b_nxt_s [B_SZ];

    logic [31:0]             idx_s;
    logic                    wr_fire_s;
    logic                    wr_a_s;
    logic                    wr_b_s;
    logic                    wr_bad_s;
    logic                    start_ok_s;
    int                      step_s;
    logic [N*DATA_WIDTH-1:0] a_word_s;
    logic [M*DATA_WIDTH-1:0] b_word_s;

    assign load_ready_o = load_ready_r;
    assign busy_o       = busy_r;
    assign feed_valid_o = feed_valid_r;
    assign a_row_o      = a_row_r;
    assign b_col_o      = b_col_r;
    assign done_o       = done_r;
    assign err_o        = err_r;

    assign idx_s = 32'(load_idx_i);

    // Write handshake decode and range check against the selected bank.
    always_comb begin
        wr_fire_s = load_valid_i & load_ready_r;
        wr_a_s    = wr_fire_s & ~load_sel_i & (idx_s < 32'(A_SZ));
        wr_b_s    = wr_fire_s &  load_sel_i & (idx_s < 32'(B_SZ));
        wr_bad_s  = wr_fire_s & ~wr_a_s & ~wr_b_s;
    end

    // Bank contents including a write landing this edge; the t=0 word is
    // built from these so a write taken together with start is fed.
    always_comb begin
        bank_a_nxt_s = bank_a_r;
        bank_b_nxt_s = bank_b_r;
        for (int e = 0; e < A_SZ; e++) begin
            if (wr_a_s && (idx_s == 32'(e))) begin
                bank_a_nxt_s[e] = load_data_i;
            end else begin
                bank_a_nxt_s[e] = bank_a_r[e];
            end
        end
        for (int e = 0; e < B_SZ; e++) begin
            if (wr_b_s && (idx_s == 32'(e))) begin
                bank_b_nxt_s[e] = load_data_i;
            end else begin
                bank_b_nxt_s[e] = bank_b_r[e];
            end
        end
    end

    // Step whose word is registered at the coming edge: 0 when launching
    // from idle, t+1 while feeding.
    always_comb begin
        if (state_r == ST_FEED) begin
            step_s = 32'(t_r) + 32'd1;
        end else begin
            step_s = 32'sd0;
        end
    end

    // Skewed edge words: lane i of A carries A[i][s-i], lane j of B carries
    // B[s-j][j]; at most one k matches per lane, others contribute zero.
    always_comb begin
        a_word_s = {(N*DATA_WIDTH){1'b0}};
        b_word_s = {(M*DATA_WIDTH){1'b0}};
        for (int i = 0; i < N; i++) begin
            for (int k = 0; k < K; k++) begin
                a_word_s[i*DATA_WIDTH +: DATA_WIDTH] = a_word_s[i*DATA_WIDTH +: DATA_WIDTH]
                    | ((step_s == i + k) ? bank_a_nxt_s[i*K + k] : {DATA_WIDTH{1'b0}});
            end
        end
        for (int j = 0; j < M; j++) begin
            for (int k = 0; k < K; k++) begin
                b_word_s[j*DATA_WIDTH +: DATA_WIDTH] = b_word_s[j*DATA_WIDTH +: DATA_WIDTH]
                    | ((step_s == k + j) ? bank_b_nxt_s[k*M + j] : {DATA_WIDTH{1'b0}});
            end
        end
    end

`ifdef MATMUL_FEEDER_LOADCHK_EN
    logic [A_SZ-1:0] seen_a_r;
    logic [B_SZ-1:0] seen_b_r;
    logic [A_SZ-1:0] seen_a_nxt_s;
    logic [B_SZ-1:0] seen_b_nxt_s;

    // Written-element bitmaps including this edge's write; start needs all set.
    always_comb begin
        seen_a_nxt_s = seen_a_r;
        seen_b_nxt_s = seen_b_r;
        for (int e = 0; e < A_SZ; e++) begin
            seen_a_nxt_s[e] = seen_a_r[e] | (wr_a_s & (idx_s == 32'(e)));
        end
        for (int e = 0; e < B_SZ; e++) begin
            seen_b_nxt_s[e] = seen_b_r[e] | (wr_b_s & (idx_s == 32'(e)));
        end
        start_ok_s = (&seen_a_nxt_s) & (&seen_b_nxt_s);
    end

    // Bitmap registers, cleared on reset and at the end of every feed.
    always_ff @(posedge clk) begin
        if (!rst_ni) begin
            seen_a_r <= {A_SZ{1'b0}};
            seen_b_r <= {B_SZ{1'b0}};
        end else if (state_r == ST_DONE) begin
            seen_a_r <= {A_SZ{1'b0}};
            seen_b_r <= {B_SZ{1'b0}};
        end else begin
            seen_a_r <= seen_a_nxt_s;
            seen_b_r <= seen_b_nxt_s;
        end
    end
`else
    assign start_ok_s = 1'b1;
`endif

    // Operand banks; only idle-state writes ever change them.
    always_ff @(posedge clk) begin
        if (!rst_ni) begin
            for (int e = 0; e < A_SZ; e++) begin
                bank_a_r[e] <= {DATA_WIDTH{1'b0}};
            end
            for (int e = 0; e < B_SZ; e++) begin
                bank_b_r[e] <= {DATA_WIDTH{1'b0}};
            end
        end else begin
            bank_a_r <= bank_a_nxt_s;
            bank_b_r <= bank_b_nxt_s;
        end
    end

    // Control FSM with all block outputs registered.
    always_ff @(posedge clk) begin
        if (!rst_ni) begin
            state_r      <= ST_IDLE;
            t_r          <= {TW{1'b0}};
            load_ready_r <= 1'b1;
            busy_r       <= 1'b0;
            feed_valid_r <= 1'b0;
            done_r       <= 1'b0;
            err_r        <= 1'b0;
            a_row_r      <= {(N*DATA_WIDTH){1'b0}};
            b_col_r      <= {(M*DATA_WIDTH){1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    err_r  <= wr_bad_s | (start_i & ~start_ok_s);
                    if (start_i && start_ok_s) begin
                        state_r      <= ST_FEED;
                        t_r          <= {TW{1'b0}};
                        load_ready_r <= 1'b0;
                        busy_r       <= 1'b1;
                        feed_valid_r <= 1'b1;
                        a_row_r      <= a_word_s;
                        b_col_r      <= b_word_s;
                    end else begin
                        state_r      <= ST_IDLE;
                        load_ready_r <= 1'b1;
                        busy_r       <= 1'b0;
                        feed_valid_r <= 1'b0;
                        a_row_r      <= {(N*DATA_WIDTH){1'b0}};
                        b_col_r      <= {(M*DATA_WIDTH){1'b0}};
                    end
                end
                ST_FEED: begin
                    err_r <= 1'b0;
                    if (t_r == T_LAST) begin
                        state_r      <= ST_DONE;
                        feed_valid_r <= 1'b0;
                        done_r       <= 1'b1;
                        a_row_r      <= {(N*DATA_WIDTH){1'b0}};
                        b_col_r      <= {(M*DATA_WIDTH){1'b0}};
                    end else begin
                        state_r      <= ST_FEED;
                        t_r          <= t_r + {{(TW-1){1'b0}}, 1'b1};
                        feed_valid_r <= 1'b1;
                        done_r       <= 1'b0;
                        a_row_r      <= a_word_s;
                        b_col_r      <= b_word_s;
                    end
                end
                ST_DONE: begin
                    state_r      <= ST_IDLE;
                    load_ready_r <= 1'b1;
                    busy_r       <= 1'b0;
                    feed_valid_r <= 1'b0;
                    done_r       <= 1'b0;
                    err_r        <= 1'b0;
                    a_row_r      <= {(N*DATA_WIDTH){1'b0}};
                    b_col_r      <= {(M*DATA_WIDTH){1'b0}};
                end
                default: begin
                    state_r      <= ST_IDLE;
                    t_r          <= {TW{1'b0}};
                    load_ready_r <= 1'b1;
                    busy_r       <= 1'b0;
                    feed_valid_r <= 1'b0;
                    done_r       <= 1'b0;
                    err_r        <= 1'b0;
                    a_row_r      <= {(N*DATA_WIDTH){1'b0}};
                    b_col_r      <= {(M*DATA_WIDTH){1'b0}};
                end
            endcase
        end
    end

endmodule

// File: tb/tb_matmul_operand_feeder.sv
// -----------------------------------------------------------------------------
// tb_matmul_operand_feeder
//
// Directed bench for matmul_operand_feeder using two configurations:
//   u0: N=K=M=2      (T = 3)
//   u1: N=2,K=3,M=1  (T = 4)
// Inputs change just after the falling edge; outputs are checked at the
// falling edge, half a cycle after the rising edge that produced them.
// -----------------------------------------------------------------------------
module tb_matmul_operand_feeder;

    logic clk = 1'b0;
    logic rst_n;

    // u0 signals (2x2x2)
    logic        v0, sel0, st0;
    logic [1:0]  idx0;
    logic [7:0]  dat0;
    logic        rdy0, busy0, fv0, done0, err0;
    logic [15:0] a0, b0;

    // u1 signals (2x3x1)
    logic        v1, sel1, st1;
    logic [2:0]  idx1;
    logic [7:0]  dat1;
    logic        rdy1, busy1, fv1, done1, err1;
    logic [15:0] a1;
    logic [7:0]  b1;

    int n_cmp = 0;
    int n_err = 0;
    int cnt;

    matmul_operand_feeder #(.N(2), .K(2), .M(2), .DATA_WIDTH(8)) u0 (
        .clk(clk), .rst_ni(rst_n),
        .load_valid_i(v0), .load_ready_o(rdy0), .load_sel_i(sel0),
        .load_idx_i(idx0), .load_data_i(dat0), .start_i(st0),
        .busy_o(busy0), .feed_valid_o(fv0), .a_row_o(a0), .b_col_o(b0),
        .done_o(done0), .err_o(err0)
    );

    matmul_operand_feeder #(.N(2), .K(3), .M(1), .DATA_WIDTH(8)) u1 (
        .clk(clk), .rst_ni(rst_n),
        .load_valid_i(v1), .load_ready_o(rdy1), .load_sel_i(sel1),
        .load_idx_i(idx1), .load_data_i(dat1), .start_i(st1),
        .busy_o(busy1), .feed_valid_o(fv1), .a_row_o(a1), .b_col_o(b1),
        .done_o(done1), .err_o(err1)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wr0(input logic sel, input logic [1:0] idx, input logic [7:0] d);
        v0 = 1'b1; sel0 = sel; idx0 = idx; dat0 = d;
        tick();
        v0 = 1'b0;
    endtask

    task automatic wr1(input logic sel, input logic [2:0] idx, input logic [7:0] d);
        v1 = 1'b1; sel1 = sel; idx1 = idx; dat1 = d;
        tick();
        v1 = 1'b0;
    endtask

    task automatic load_u0_abcd();
        wr0(1'b0, 2'd0, 8'd1); wr0(1'b0, 2'd1, 8'd2);
        wr0(1'b0, 2'd2, 8'd3); wr0(1'b0, 2'd3, 8'd4);
        wr0(1'b1, 2'd0, 8'd5); wr0(1'b1, 2'd1, 8'd6);
        wr0(1'b1, 2'd2, 8'd7); wr0(1'b1, 2'd3, 8'd8);
    endtask

    // Feed of A=[[1,2,3],[4,5,6]], B=[[7],[8],[9]] on u1, with done check.
    task automatic feed_u1(input string tag);
        st1 = 1'b1; tick(); st1 = 1'b0;
        chk({tag, "_t0_fv"}, 32'(fv1), 32'd1);
        chk({tag, "_t0_a"}, 32'(a1), 32'h0001);
        chk({tag, "_t0_b"}, 32'(b1), 32'h07);
        tick();
        chk({tag, "_t1_a"}, 32'(a1), 32'h0402);
        chk({tag, "_t1_b"}, 32'(b1), 32'h08);
        tick();
        chk({tag, "_t2_a"}, 32'(a1), 32'h0503);
        chk({tag, "_t2_b"}, 32'(b1), 32'h09);
        tick();
        chk({tag, "_t3_fv"}, 32'(fv1), 32'd1);
        chk({tag, "_t3_a"}, 32'(a1), 32'h0600);
        chk({tag, "_t3_b"}, 32'(b1), 32'h00);
        tick();
        chk({tag, "_done"}, 32'(done1), 32'd1);
        chk({tag, "_done_fv"}, 32'(fv1), 32'd0);
        chk({tag, "_done_a"}, 32'(a1), 32'h0000);
        tick();
        chk({tag, "_idle_done"}, 32'(done1), 32'd0);
        chk({tag, "_idle_rdy"}, 32'(rdy1), 32'd1);
    endtask

    initial begin
        rst_n = 1'b0;
        v0 = 1'b0; sel0 = 1'b0; st0 = 1'b0; idx0 = 2'd0; dat0 = 8'd0;
        v1 = 1'b0; sel1 = 1'b0; st1 = 1'b0; idx1 = 3'd0; dat1 = 8'd0;
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // Reset state
        chk("rst_rdy", 32'(rdy0), 32'd1);
        chk("rst_busy", 32'(busy0), 32'd0);
        chk("rst_fv", 32'(fv0), 32'd0);
        chk("rst_done", 32'(done0), 32'd0);
        chk("rst_err", 32'(err0), 32'd0);
        chk("rst_a", 32'(a0), 32'h0000);
        chk("rst_b", 32'(b0), 32'h0000);

        // 2x2 feed, with a start pulse during FEED that must be ignored
        load_u0_abcd();
        chk("wr_ok_err", 32'(err0), 32'd0);
        st0 = 1'b1; tick(); st0 = 1'b0;
        chk("f1_t0_fv", 32'(fv0), 32'd1);
        chk("f1_t0_a", 32'(a0), 32'h0001);
        chk("f1_t0_b", 32'(b0), 32'h0005);
        chk("f1_t0_busy", 32'(busy0), 32'd1);
        chk("f1_t0_rdy", 32'(rdy0), 32'd0);
        tick();
        chk("f1_t1_a", 32'(a0), 32'h0302);
        chk("f1_t1_b", 32'(b0), 32'h0607);
        st0 = 1'b1;
        tick();
        st0 = 1'b0;
        chk("f1_t2_fv", 32'(fv0), 32'd1);
        chk("f1_t2_a", 32'(a0), 32'h0400);
        chk("f1_t2_b", 32'(b0), 32'h0800);
        chk("f1_t2_err", 32'(err0), 32'd0);
        tick();
        chk("f1_done", 32'(done0), 32'd1);
        chk("f1_done_fv", 32'(fv0), 32'd0);
        chk("f1_done_a", 32'(a0), 32'h0000);
        chk("f1_done_b", 32'(b0), 32'h0000);
        chk("f1_done_busy", 32'(busy0), 32'd1);
        tick();
        chk("f1_idle_done", 32'(done0), 32'd0);
        chk("f1_idle_busy", 32'(busy0), 32'd0);
        chk("f1_idle_rdy", 32'(rdy0), 32'd1);
        tick();
        chk("f1_nostart_fv", 32'(fv0), 32'd0);

        // 2x3x1 feed
        wr1(1'b0, 3'd0, 8'd1); wr1(1'b0, 3'd1, 8'd2); wr1(1'b0, 3'd2, 8'd3);
        wr1(1'b0, 3'd3, 8'd4); wr1(1'b0, 3'd4, 8'd5); wr1(1'b0, 3'd5, 8'd6);
        wr1(1'b1, 3'd0, 8'd7); wr1(1'b1, 3'd1, 8'd8); wr1(1'b1, 3'd2, 8'd9);
        feed_u1("f2");

        // Out-of-range writes are dropped with a single err pulse
        wr1(1'b0, 3'd6, 8'hAA);
        chk("oor_a_err", 32'(err1), 32'd1);
        chk("oor_a_fv", 32'(fv1), 32'd0);
        tick();
        chk("oor_a_err_clr", 32'(err1), 32'd0);
        wr1(1'b1, 3'd3, 8'hBB);
        chk("oor_b_err", 32'(err1), 32'd1);
        tick();
        chk("oor_b_err_clr", 32'(err1), 32'd0);
`ifndef MATMUL_FEEDER_LOADCHK_EN
        feed_u1("f3");

        // Reset while feeding aborts without done
        st0 = 1'b1; tick(); st0 = 1'b0;
        tick();
        chk("ab_t1_a", 32'(a0), 32'h0302);
        rst_n = 1'b0;
        tick();
        chk("ab_fv", 32'(fv0), 32'd0);
        chk("ab_a", 32'(a0), 32'h0000);
        chk("ab_b", 32'(b0), 32'h0000);
        chk("ab_busy", 32'(busy0), 32'd0);
        chk("ab_done", 32'(done0), 32'd0);
        rst_n = 1'b1;
        tick();
        chk("ab_rel_done", 32'(done0), 32'd0);
        chk("ab_rel_rdy", 32'(rdy0), 32'd1);
        st0 = 1'b1; tick(); st0 = 1'b0;
        chk("z_t0_fv", 32'(fv0), 32'd1);
        chk("z_t0_a", 32'(a0), 32'h0000);
        chk("z_t0_b", 32'(b0), 32'h0000);
        tick();
        chk("z_t1_a", 32'(a0), 32'h0000);
        chk("z_t1_b", 32'(b0), 32'h0000);
        tick(); tick(); tick();
        chk("z_idle_rdy", 32'(rdy0), 32'd1);

        // Write taken on the same edge as start is part of the feed
        v0 = 1'b1; sel0 = 1'b0; idx0 = 2'd0; dat0 = 8'd9; st0 = 1'b1;
        tick();
        v0 = 1'b0; st0 = 1'b0;
        chk("sw_t0_a", 32'(a0), 32'h0009);
        chk("sw_t0_b", 32'(b0), 32'h0000);
        cnt = 0;
        for (int c = 0; c < 20 && rdy0 == 1'b0; c++) begin
            cnt++;
            tick();
        end
        chk("sw_ready_low_cycles", 32'(cnt), 32'd4);
`else
        // Start refused until every element of both banks is written
        tick();
        load_u0_abcd();
        st0 = 1'b1; tick(); st0 = 1'b0;
        chk("lc_part_fv", 32'(fv0), 32'd1);
        cnt = 0;
        for (int c = 0; c < 20 && rdy0 == 1'b0; c++) begin
            cnt++;
            tick();
        end
        chk("lc_full_len", 32'(cnt), 32'd4);
        wr0(1'b0, 2'd0, 8'd1); wr0(1'b0, 2'd1, 8'd2);
        wr0(1'b0, 2'd2, 8'd3); wr0(1'b0, 2'd3, 8'd4);
        wr0(1'b1, 2'd0, 8'd5); wr0(1'b1, 2'd1, 8'd6); wr0(1'b1, 2'd2, 8'd7);
        st0 = 1'b1; tick(); st0 = 1'b0;
        chk("lc_ref_err", 32'(err0), 32'd1);
        chk("lc_ref_fv", 32'(fv0), 32'd0);
        chk("lc_ref_rdy", 32'(rdy0), 32'd1);
        tick();
        chk("lc_ref_err_clr", 32'(err0), 32'd0);
        wr0(1'b1, 2'd3, 8'd8);
        st0 = 1'b1; tick(); st0 = 1'b0;
        chk("lc_ok_fv", 32'(fv0), 32'd1);
        chk("lc_ok_a", 32'(a0), 32'h0001);
        chk("lc_ok_b", 32'(b0), 32'h0005);
        chk("lc_ok_err", 32'(err0), 32'd0);
        tick(); tick(); tick();
        chk("lc_ok_done", 32'(done0), 32'd1);
        tick();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
